// File: rtl/systolic_processor_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_processor_stream_if
//  Brief    : Job control, operand stream and result bus of the systolic array.
//  Revision : 1.0
// ============================================================================
interface systolic_processor_stream_if #(
    parameter int SIZE   = 4,
    parameter int I_BITS = 8,
    parameter int K_MAX  = 16,
    parameter int O_BITS = 2*I_BITS+$clog2(K_MAX),
    parameter int KW     = $clog2(K_MAX)+1
);
    logic                        i_start;
    logic [KW-1:0]               i_k;
    logic                        i_signed;
    logic                        i_valid;
    logic                        o_ready;
    logic [SIZE*I_BITS-1:0]      i_a_full;
    logic [SIZE*I_BITS-1:0]      i_b_full;
    logic [SIZE*SIZE*O_BITS-1:0] o_c_full;
    logic                        o_done;
    logic                        o_busy;

    modport master (
        output i_start, i_k, i_signed, i_valid, i_a_full, i_b_full,
        input  o_ready, o_c_full, o_done, o_busy
    );

    modport slave (
        input  i_start, i_k, i_signed, i_valid, i_a_full, i_b_full,
        output o_ready, o_c_full, o_done, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/systolic_processor_stream.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_processor_stream
//  Brief    : Output-stationary SIZExSIZE systolic array computing C = A*B
//             with run-time inner dimension, input skew and held result.
//  Revision : 1.0
// ============================================================================
module systolic_processor_stream #(
    parameter int SIZE   = 4,
    parameter int I_BITS = 8,
    parameter int K_MAX  = 16,
    parameter int O_BITS = 2*I_BITS+$clog2(K_MAX),
    parameter int KW     = $clog2(K_MAX)+1
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    systolic_processor_stream_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam int         DW       = $clog2(2*SIZE+1);
    localparam int         PW       = 2*I_BITS;
    localparam int         GW       = O_BITS-PW;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] beat_q, beat_d;
    logic          signed_q, signed_d;
    logic [DW-1:0] drain_q, drain_d;

    logic          w_accept;
    logic          w_clear;
    logic          w_capture;
    logic [KW-1:0] w_k_clamped;

    logic [I_BITS-1:0] w_a_in [SIZE][SIZE];
    logic [I_BITS-1:0] w_b_in [SIZE][SIZE];

    assign w_accept    = bus.i_valid && (state_q == ST_LOAD);
    assign w_clear     = bus.i_start && (state_q == ST_IDLE);
    assign w_capture   = (state_q == ST_DRAIN) && (drain_q == '0);
    assign w_k_clamped = (bus.i_k > KW'(K_MAX)) ? KW'(K_MAX) : bus.i_k;

    assign bus.o_ready = (state_q == ST_LOAD);
    assign bus.o_done  = (state_q == ST_DONE);
    assign bus.o_busy  = (state_q == ST_LOAD) || (state_q == ST_DRAIN);

    // The drain count differs by path so that the K=0 job ends one cycle
    // later than a job whose last beat landed on the same edge.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        beat_d   = beat_q;
        signed_d = signed_q;
        drain_d  = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    k_d      = w_k_clamped;
                    signed_d = bus.i_signed;
                    beat_d   = '0;
                    if (w_k_clamped == '0) begin
                        state_d = ST_DRAIN;
                        drain_d = DW'(2*SIZE);
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q + KW'(1) == k_q) begin
                        state_d = ST_DRAIN;
                        drain_d = DW'(2*SIZE-1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            beat_q   <= '0;
            signed_q <= 1'b0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            beat_q   <= beat_d;
            signed_q <= signed_d;
            drain_q  <= drain_d;
        end
    end

    // Row i of A is delayed by i stages beyond the capture stage; non-beats
    // enter as zero so bubbles and drain cycles add nothing to the sums.
    for (genvar i = 0; i < SIZE; i++) begin : g_skew_a
        logic [I_BITS-1:0] a_sk_q [0:i];
        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                for (int s = 0; s <= i; s++) a_sk_q[s] <= '0;
            end else begin
                a_sk_q[0] <= w_accept ? bus.i_a_full[i*I_BITS +: I_BITS] : '0;
                for (int s = 1; s <= i; s++) a_sk_q[s] <= a_sk_q[s-1];
            end
        end
        assign w_a_in[i][0] = a_sk_q[i];
    end

    for (genvar j = 0; j < SIZE; j++) begin : g_skew_b
        logic [I_BITS-1:0] b_sk_q [0:j];
        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                for (int s = 0; s <= j; s++) b_sk_q[s] <= '0;
            end else begin
                b_sk_q[0] <= w_accept ? bus.i_b_full[j*I_BITS +: I_BITS] : '0;
                for (int s = 1; s <= j; s++) b_sk_q[s] <= b_sk_q[s-1];
            end
        end
        assign w_b_in[0][j] = b_sk_q[j];
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_pe_row
        for (genvar j = 0; j < SIZE; j++) begin : g_pe_col
            logic [PW-1:0]     w_a_ext;
            logic [PW-1:0]     w_b_ext;
            logic [PW-1:0]     w_prod;
            logic [O_BITS-1:0] w_prod_ext;
            logic [O_BITS-1:0] acc_q;
            logic [O_BITS-1:0] c_q;

            assign w_a_ext = signed_q ? {{I_BITS{w_a_in[i][j][I_BITS-1]}}, w_a_in[i][j]}
                                      : {{I_BITS{1'b0}}, w_a_in[i][j]};
            assign w_b_ext = signed_q ? {{I_BITS{w_b_in[i][j][I_BITS-1]}}, w_b_in[i][j]}
                                      : {{I_BITS{1'b0}}, w_b_in[i][j]};
            // The low 2*I_BITS bits of the extended product are exact for both modes.
            assign w_prod     = w_a_ext * w_b_ext;
            assign w_prod_ext = signed_q ? {{GW{w_prod[PW-1]}}, w_prod}
                                         : {{GW{1'b0}}, w_prod};

            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) begin
                    acc_q <= '0;
                end else if (w_clear) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_q + w_prod_ext;
                end
            end

            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) begin
                    c_q <= '0;
                end else if (w_capture) begin
                    c_q <= acc_q;
                end
            end
            assign bus.o_c_full[(i*SIZE+j)*O_BITS +: O_BITS] = c_q;

            if (j < SIZE-1) begin : g_fwd_a
                logic [I_BITS-1:0] a_q;
                always_ff @(posedge i_clock or posedge i_reset) begin
                    if (i_reset) a_q <= '0;
                    else         a_q <= w_a_in[i][j];
                end
                assign w_a_in[i][j+1] = a_q;
            end

            if (i < SIZE-1) begin : g_fwd_b
                logic [I_BITS-1:0] b_q;
                always_ff @(posedge i_clock or posedge i_reset) begin
                    if (i_reset) b_q <= '0;
                    else         b_q <= w_b_in[i][j];
                end
                assign w_b_in[i+1][j] = b_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_systolic_processor_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_processor_stream
//  Brief    : Table-driven, scoreboarded bench for systolic_processor_stream.
//  Revision : 1.0
// ============================================================================
module tb_systolic_processor_stream;
    localparam int SIZE   = 4;
    localparam int I_BITS = 8;
    localparam int K_MAX  = 16;
    localparam int O_BITS = 2*I_BITS+$clog2(K_MAX);
    localparam int KW     = $clog2(K_MAX)+1;
    localparam int CW     = SIZE*SIZE*O_BITS;
    localparam int AW     = SIZE*I_BITS;

    typedef struct {
        int                k;
        bit                sgn;
        int                gap;
        int                pat;
        int                av;
        int                bv;
        bit                pulse;
        logic [O_BITS-1:0] exp00;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_processor_stream_if #(
        .SIZE(SIZE), .I_BITS(I_BITS), .K_MAX(K_MAX), .O_BITS(O_BITS), .KW(KW)
    ) bus ();

    systolic_processor_stream #(
        .SIZE(SIZE), .I_BITS(I_BITS), .K_MAX(K_MAX), .O_BITS(O_BITS), .KW(KW)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int              cyc = 0;
    int              checks = 0;
    int              failures = 0;
    int              done_cnt = 0;
    int              done_cyc = 0;
    logic [CW-1:0]   last_c = '0;
    logic [CW-1:0]   c_contig = '0;
    logic [CW-1:0]   mon_e;
    logic [CW-1:0]   exp_q [$];
    logic [I_BITS-1:0] opa [SIZE][K_MAX];
    logic [I_BITS-1:0] opb [K_MAX][SIZE];
    vec_t            tbl [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            last_c   = bus.o_c_full;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("c_matrix", bus.o_c_full, mon_e);
            end
        end
    end

    function automatic longint ext(input logic [I_BITS-1:0] v, input bit sgn);
        if (sgn) return longint'($signed(v));
        return longint'(v);
    endfunction

    function automatic logic [CW-1:0] model(input int k, input bit sgn);
        logic [CW-1:0] r = '0;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                longint s = 0;
                for (int kk = 0; kk < k; kk++) s += ext(opa[i][kk], sgn) * ext(opb[kk][j], sgn);
                r[(i*SIZE+j)*O_BITS +: O_BITS] = s[O_BITS-1:0];
            end
        end
        return r;
    endfunction

    task automatic fill_ops(input vec_t v);
        for (int kk = 0; kk < K_MAX; kk++) begin
            for (int n = 0; n < SIZE; n++) begin
                case (v.pat)
                    0: begin
                        opa[n][kk] = (n == kk) ? I_BITS'(1) : I_BITS'(0);
                        opb[kk][n] = I_BITS'(SIZE*kk + n + 1);
                    end
                    1: begin
                        opa[n][kk] = I_BITS'(v.av);
                        opb[kk][n] = I_BITS'(v.bv);
                    end
                    default: begin
                        opa[n][kk] = I_BITS'(n*37 + kk*11 + 200);
                        opb[kk][n] = I_BITS'(n*53 + kk*29 + 100);
                    end
                endcase
            end
        end
    endtask

    task automatic drive_beat(input int b);
        for (int n = 0; n < SIZE; n++) begin
            bus.i_a_full[n*I_BITS +: I_BITS] = opa[n][b];
            bus.i_b_full[n*I_BITS +: I_BITS] = opb[b][n];
        end
    endtask

    task automatic run_job(input vec_t v);
        int            s_edge, e_edge, exp_done, n, d0;
        bit            got;
        logic [CW-1:0] exp_c;
        fill_ops(v);
        exp_c = model(v.k, v.sgn);
        exp_q.push_back(exp_c);
        check("ready_in_idle", bus.o_ready, 0);
        bus.i_start  = 1'b1;
        bus.i_k      = KW'(v.k);
        bus.i_signed = v.sgn;
        @(posedge clk); #1;
        s_edge = cyc;
        e_edge = cyc;
        bus.i_start = 1'b0;
        for (int b = 0; b < v.k; b++) begin
            if (b > 0) begin
                repeat (v.gap) begin
                    bus.i_valid  = 1'b0;
                    bus.i_a_full = AW'($urandom());
                    bus.i_b_full = AW'($urandom());
                    bus.i_start  = v.pulse ? 1'($urandom_range(0, 1)) : 1'b0;
                    @(posedge clk); #1;
                end
            end
            bus.i_valid = 1'b1;
            drive_beat(b);
            bus.i_start = v.pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            check("ready_in_load", bus.o_ready, 1);
            @(posedge clk); #1;
            e_edge = cyc;
        end
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
        check("ready_after_last", bus.o_ready, 0);
        check("busy_in_drain", bus.o_busy, 1);
        exp_done = (v.k == 0) ? s_edge + 1 + 2*SIZE : e_edge + 2*SIZE;
        d0  = done_cnt;
        got = 1'b0;
        n   = 0;
        while (!got && n < 200) begin
            if (v.pulse && n < 3) begin
                bus.i_start  = 1'b1;
                bus.i_valid  = 1'b1;
                bus.i_a_full = AW'($urandom());
                bus.i_b_full = AW'($urandom());
            end else begin
                bus.i_start = 1'b0;
                bus.i_valid = 1'b0;
            end
            @(posedge clk); #2;
            if (done_cnt != d0) got = 1'b1;
            n++;
        end
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=o_done (t=%0t)", $time);
            exp_q.delete();
        end else begin
            check("done_time", done_cyc, exp_done);
            check("busy_at_done", bus.o_busy, 0);
            check("c00", last_c[O_BITS-1:0], v.exp00);
            @(posedge clk); #1;
            check("done_width", bus.o_done, 0);
            check("c_held", bus.o_c_full, exp_c);
        end
    endtask

    task automatic abort_seq();
        int d0;
        bus.i_start  = 1'b1;
        bus.i_k      = KW'(4);
        bus.i_signed = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (2) begin
            bus.i_valid  = 1'b1;
            bus.i_a_full = AW'($urandom());
            bus.i_b_full = AW'($urandom());
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("abort_c_clear", bus.o_c_full, 0);
        check("abort_busy", bus.o_busy, 0);
        check("abort_ready", bus.o_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3*SIZE + 4) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", done_cnt, d0);
    endtask

    initial begin
        tbl[0] = '{4,  1'b0, 0, 0, 0,    0,    1'b0, 20'h00001};
        tbl[1] = '{16, 1'b1, 0, 1, 'hFF, 'h7F, 1'b0, 20'hFF810};
        tbl[2] = '{16, 1'b0, 0, 1, 'hFF, 'h7F, 1'b0, 20'h7E810};
        tbl[3] = '{3,  1'b0, 0, 2, 0,    0,    1'b0, 20'h14177};
        tbl[4] = '{3,  1'b0, 2, 2, 0,    0,    1'b0, 20'h14177};
        tbl[5] = '{0,  1'b0, 0, 1, 0,    0,    1'b0, 20'h00000};
        tbl[6] = '{16, 1'b0, 0, 1, 'hFF, 'hFF, 1'b0, 20'hFE010};
        tbl[7] = '{4,  1'b1, 1, 2, 0,    0,    1'b1, 20'h013AA};

        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            bus.i_start  = 1'($urandom_range(0, 1));
            bus.i_k      = KW'($urandom());
            bus.i_signed = 1'($urandom_range(0, 1));
            bus.i_valid  = 1'($urandom_range(0, 1));
            bus.i_a_full = AW'($urandom());
            bus.i_b_full = AW'($urandom());
            @(posedge clk); #1;
            check("rst_c", bus.o_c_full, 0);
            check("rst_ready", bus.o_ready, 0);
            check("rst_done", bus.o_done, 0);
            check("rst_busy", bus.o_busy, 0);
        end
        bus.i_start  = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_k      = '0;
        bus.i_signed = 1'b0;
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("no_done_after_reset", done_cnt, 0);

        for (int t = 0; t < 8; t++) begin
            if (t == 7) abort_seq();
            run_job(tbl[t]);
            if (t == 3) c_contig = last_c;
            if (t == 4) check("bubble_equals_contig", last_c, c_contig);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
